elevator_scheduler: RTL and testbench
=====================================

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter DOOR_TIME, default 50, is the door-open dwell in clk cycles.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 button_n  input  3  floor call buttons, active-low, asynchronous to clk; bit i is floor i.
REQ-005 move_clk  input  1  movement pacing from the frequency block; each rising edge is one floor of travel.
REQ-006 sos_mode  input  1  emergency stop, active-high level.
REQ-007 weight_limit_exceeded  input  1  overload, active-high level.
REQ-008 floor  output  2  current floor, 0..2.
REQ-009 moving  output  1  high in MOVE_UP or MOVE_DOWN.
REQ-010 direction  output  1  1 = up, 0 = down; last travel direction.
REQ-011 door_open  output  1  high only in DOOR.
REQ-012 pending  output  3  latched, unserved calls, one bit per floor.
REQ-013 arrived  output  1  one-cycle pulse when the car stops at a called floor.

Function
REQ-014 Each button_n bit shall pass through a 2-flop synchronizer; a registered falling-edge detect shall set the matching pending bit; a call shall be visible on pending no later than 3 clk cycles after the button falls.
REQ-015 move_clk shall be synchronized the same way; a one-cycle move_tick shall be generated on each synchronized rising edge.
REQ-016 The FSM shall have the states IDLE, MOVE_UP, MOVE_DOWN, DOOR and SOS.
REQ-017 IDLE: with a pending bit at floor, the FSM shall go to DOOR, clear that bit and pulse arrived.
REQ-018 IDLE: otherwise, with any pending bit above floor, the FSM shall go to MOVE_UP.
REQ-019 IDLE: otherwise, with any pending bit below floor, the FSM shall go to MOVE_DOWN.
REQ-020 IDLE with weight_limit_exceeded high shall remain in IDLE; calls keep latching.
REQ-021 MOVE_UP/MOVE_DOWN: each move_tick shall change floor by +1/-1 in the same cycle; floor shall never go below 0 or above 2.
REQ-022 After a floor step, if the pending bit of the new floor is set, the next cycle shall enter DOOR, clear that bit and pulse arrived; otherwise the FSM shall keep moving.
REQ-023 move_tick in IDLE, DOOR or SOS shall be ignored.
REQ-024 DOOR shall load the dwell counter with DOOR_TIME-1 and decrement it once per cycle.
REQ-025 In DOOR, weight_limit_exceeded high, or a new call for the current floor, shall reload the counter; a call for the current floor shall not set pending.
REQ-026 When the counter reaches 0 with weight_limit_exceeded low, DOOR shall exit: continue in direction if calls remain beyond floor in that direction, else reverse if calls remain the other way, else go to IDLE.
REQ-027 direction shall update on entry to MOVE_UP (1) or MOVE_DOWN (0) and hold otherwise.
REQ-028 A call arriving in the same cycle that its floor is cleared shall be absorbed, not latched.
REQ-029 sos_mode high in any state shall force SOS on the next edge: moving=0, door_open=0, pending cleared, new calls ignored, floor held.
REQ-030 SOS shall exit to IDLE on the first cycle sos_mode is low.
REQ-031 sos_mode shall take priority over every other event in the same cycle.

Reset
REQ-032 reset_n low shall immediately force: state IDLE, floor=0, direction=1, moving=0, door_open=0, pending=000, arrived=0, dwell counter=0, synchronizers idle (button high, move_clk low).
REQ-033 Reset asserted mid-move or mid-dwell shall abandon the operation; no pending call shall survive reset.
REQ-034 The first state change after reset_n rises shall occur no earlier than the second rising clk edge.

Verification
REQ-035 At floor 0, press button 2 -> pending=100, MOVE_UP, floor 1 after tick 1 with no stop, floor 2 after tick 2, arrived pulse, door_open for DOOR_TIME cycles, then IDLE with pending=000.
REQ-036 At floor 0, press 2, then press 1 before tick 1 -> stop at floor 1 (door), then continue up to 2, direction stays 1 throughout.
REQ-037 At floor 1 moving up with calls for 2 and 0 -> serve 2, then reverse; direction=0, serve 0, then IDLE.
REQ-038 In DOOR, hold weight_limit_exceeded for 3*DOOR_TIME cycles -> door_open stays 1; it closes DOOR_TIME cycles after release.
REQ-039 Assert sos_mode while moving between ticks with pending=101 -> next cycle state SOS, moving=0, pending=000, and later ticks leave floor unchanged; release -> IDLE.
REQ-040 Pulse reset_n low during DOOR at floor 2 -> all outputs at reset values immediately, floor=0.

Source files
------------

// File: rtl/elevator_scheduler_if.sv
// Call, pacing and status signals of the elevator car controller.
// The controller uses the slave modport; whoever drives the car inputs uses master.
interface elevator_scheduler_if;
  logic [2:0] button_n;
  logic       move_clk;
  logic       sos_mode;
  logic       weight_limit_exceeded;
  logic [1:0] floor;
  logic       moving;
  logic       direction;
  logic       door_open;
  logic [2:0] pending;
  logic       arrived;

  modport master (
    output button_n, move_clk, sos_mode, weight_limit_exceeded,
    input  floor, moving, direction, door_open, pending, arrived
  );

  modport slave (
    input  button_n, move_clk, sos_mode, weight_limit_exceeded,
    output floor, moving, direction, door_open, pending, arrived
  );
endinterface

// File: rtl/elevator_scheduler.sv
// Three-floor elevator car scheduler: latches floor calls, paces travel from
// move_clk, dwells with the door open, and honours overload and emergency stop.
module elevator_scheduler #(
  parameter int DOOR_TIME = 50
) (
  input logic                  clk,
  input logic                  reset_n,
  elevator_scheduler_if.slave  bus
);

  localparam int DW = (DOOR_TIME > 1) ? $clog2(DOOR_TIME) : 1;
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DOOR_TIME - 1);
  localparam logic [DW-1:0] DWELL_ZERO = DW'(0);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_DOOR      = 3'd3,
    ST_SOS       = 3'd4
  } state_t;

  function automatic logic calls_above(input logic [2:0] calls, input logic [1:0] at);
    case (at)
      2'd0:    calls_above = |calls[2:1];
      2'd1:    calls_above = calls[2];
      default: calls_above = 1'b0;
    endcase
  endfunction

  function automatic logic calls_below(input logic [2:0] calls, input logic [1:0] at);
    case (at)
      2'd1:    calls_below = calls[0];
      2'd2:    calls_below = |calls[1:0];
      default: calls_below = 1'b0;
    endcase
  endfunction

  logic [2:0]    btn_meta_r, btn_sync_r, btn_prev_r;
  logic          mv_meta_r, mv_sync_r, mv_prev_r;
  logic          run_r;
  state_t        state_r, state_nxt_s;
  logic [1:0]    floor_r, floor_nxt_s;
  logic          direction_r, direction_nxt_s;
  logic [2:0]    pending_r, pending_nxt_s;
  logic          arrived_r, arrived_nxt_s;
  logic [DW-1:0] dwell_r, dwell_nxt_s;
  logic          step_r, step_nxt_s;
  logic [2:0]    fall_s, here_mask_s, clear_s, door_mask_s;
  logic          tick_s, here_s, above_s, below_s;

  assign fall_s      = btn_prev_r & ~btn_sync_r;
  assign tick_s      = mv_sync_r & ~mv_prev_r;
  assign here_mask_s = 3'b001 << floor_r;
  assign here_s      = |(pending_r & here_mask_s);
  assign above_s     = calls_above(pending_r, floor_r);
  assign below_s     = calls_below(pending_r, floor_r);
  assign door_mask_s = (state_r == ST_DOOR) ? here_mask_s : 3'b000;

  // Input synchronizers with edge-detect history; run_r holds the FSM for one edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_r <= 3'b111;
      btn_sync_r <= 3'b111;
      btn_prev_r <= 3'b111;
      mv_meta_r  <= 1'b0;
      mv_sync_r  <= 1'b0;
      mv_prev_r  <= 1'b0;
      run_r      <= 1'b0;
    end else begin
      btn_meta_r <= bus.button_n;
      btn_sync_r <= btn_meta_r;
      btn_prev_r <= btn_sync_r;
      mv_meta_r  <= bus.move_clk;
      mv_sync_r  <= mv_meta_r;
      mv_prev_r  <= mv_sync_r;
      run_r      <= 1'b1;
    end
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      floor_r     <= 2'd0;
      direction_r <= 1'b1;
      pending_r   <= 3'b000;
      arrived_r   <= 1'b0;
      dwell_r     <= DWELL_ZERO;
      step_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      floor_r     <= floor_nxt_s;
      direction_r <= direction_nxt_s;
      pending_r   <= pending_nxt_s;
      arrived_r   <= arrived_nxt_s;
      dwell_r     <= dwell_nxt_s;
      step_r      <= step_nxt_s;
    end
  end

  // Next-state logic; sos_mode overrides everything, step_r marks the cycle after a floor step.
  always_comb begin
    state_nxt_s     = state_r;
    floor_nxt_s     = floor_r;
    direction_nxt_s = direction_r;
    dwell_nxt_s     = dwell_r;
    clear_s         = 3'b000;
    arrived_nxt_s   = 1'b0;
    step_nxt_s      = 1'b0;
    if (!run_r) begin
      state_nxt_s = state_r;
    end else if (bus.sos_mode) begin
      state_nxt_s = ST_SOS;
      dwell_nxt_s = DWELL_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.weight_limit_exceeded) begin
            state_nxt_s = ST_IDLE;
          end else if (here_s) begin
            state_nxt_s   = ST_DOOR;
            clear_s       = here_mask_s;
            arrived_nxt_s = 1'b1;
            dwell_nxt_s   = DWELL_LOAD;
          end else if (above_s) begin
            state_nxt_s     = ST_MOVE_UP;
            direction_nxt_s = 1'b1;
          end else if (below_s) begin
            state_nxt_s     = ST_MOVE_DOWN;
            direction_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (step_r && here_s) begin
            state_nxt_s   = ST_DOOR;
            clear_s       = here_mask_s;
            arrived_nxt_s = 1'b1;
            dwell_nxt_s   = DWELL_LOAD;
          end else if (step_r && !((state_r == ST_MOVE_UP) ? above_s : below_s)) begin
            state_nxt_s = ST_IDLE;
          end else if (tick_s && (state_r == ST_MOVE_UP) && (floor_r != 2'd2)) begin
            floor_nxt_s = floor_r + 2'd1;
            step_nxt_s  = 1'b1;
          end else if (tick_s && (state_r == ST_MOVE_DOWN) && (floor_r != 2'd0)) begin
            floor_nxt_s = floor_r - 2'd1;
            step_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_DOOR: begin
          if (bus.weight_limit_exceeded || (|(fall_s & here_mask_s))) begin
            dwell_nxt_s = DWELL_LOAD;
          end else if (dwell_r == DWELL_ZERO) begin
            if (direction_r ? above_s : below_s) begin
              state_nxt_s = direction_r ? ST_MOVE_UP : ST_MOVE_DOWN;
            end else if (direction_r ? below_s : above_s) begin
              state_nxt_s     = direction_r ? ST_MOVE_DOWN : ST_MOVE_UP;
              direction_nxt_s = ~direction_r;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            dwell_nxt_s = dwell_r - DWELL_ONE;
          end
        end
        ST_SOS: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Call latching: a call landing on a floor being cleared, or on the open-door floor, is absorbed.
  always_comb begin
    pending_nxt_s = pending_r;
    if (!run_r) begin
      pending_nxt_s = pending_r;
    end else if (bus.sos_mode || (state_r == ST_SOS)) begin
      pending_nxt_s = 3'b000;
    end else begin
      pending_nxt_s = (pending_r & ~clear_s) | (fall_s & ~clear_s & ~door_mask_s);
    end
  end

  assign bus.floor     = floor_r;
  assign bus.moving    = (state_r == ST_MOVE_UP) || (state_r == ST_MOVE_DOWN);
  assign bus.direction = direction_r;
  assign bus.door_open = (state_r == ST_DOOR);
  assign bus.pending   = pending_r;
  assign bus.arrived   = arrived_r;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random traffic, every
// cycle compared against a floor-level behavioural model of the car.
module tb_elevator_scheduler;
  localparam int DT = 8;
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3, M_SOS = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  elevator_scheduler_if bus ();
  elevator_scheduler #(.DOOR_TIME(DT)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  int       m_mode, m_floor, m_dwell;
  bit       m_dir, m_arr, m_step, m_run;
  bit [2:0] m_calls;
  bit [2:0] b_hist [3];
  bit       mv_hist [3];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_floor = 0; m_dwell = 0; m_dir = 1'b1;
    m_arr = 1'b0; m_step = 1'b0; m_run = 1'b0; m_calls = 3'b000;
    for (int i = 0; i < 3; i++) begin
      b_hist[i] = 3'b111;
      mv_hist[i] = 1'b0;
    end
  endtask

  task automatic open_door(inout int clr, inout bit arr);
    m_mode = M_DOOR; clr = m_floor; arr = 1'b1; m_dwell = DT - 1;
  endtask

  // One clock edge of car behaviour, from the values seen just before the edge.
  task automatic model_step();
    bit [2:0] fall;
    bit tick, above, below, here, arr_n, step_n;
    int clr, pre_mode, door_floor;
    fall = b_hist[2] & ~b_hist[1];
    tick = mv_hist[1] & !mv_hist[2];
    above = 1'b0; below = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m_calls[i] && i > m_floor) above = 1'b1;
      if (m_calls[i] && i < m_floor) below = 1'b1;
    end
    here = m_calls[m_floor];
    clr = -1; arr_n = 1'b0; step_n = 1'b0;
    pre_mode = m_mode; door_floor = m_floor;
    if (m_run) begin
      if (bus.sos_mode) begin
        m_mode = M_SOS; m_dwell = 0;
      end else begin
        case (m_mode)
          M_IDLE: if (!bus.weight_limit_exceeded) begin
            if (here) open_door(clr, arr_n);
            else if (above) begin m_mode = M_UP; m_dir = 1'b1; end
            else if (below) begin m_mode = M_DOWN; m_dir = 1'b0; end
          end
          M_UP, M_DOWN: begin
            if (m_step && here) open_door(clr, arr_n);
            else if (m_step && !(m_mode == M_UP ? above : below)) m_mode = M_IDLE;
            else if (tick && m_mode == M_UP && m_floor < 2) begin m_floor++; step_n = 1'b1; end
            else if (tick && m_mode == M_DOWN && m_floor > 0) begin m_floor--; step_n = 1'b1; end
          end
          M_DOOR: begin
            if (bus.weight_limit_exceeded || fall[m_floor]) m_dwell = DT - 1;
            else if (m_dwell > 0) m_dwell--;
            else if (m_dir ? above : below) m_mode = m_dir ? M_UP : M_DOWN;
            else if (m_dir ? below : above) begin m_mode = m_dir ? M_DOWN : M_UP; m_dir = !m_dir; end
            else m_mode = M_IDLE;
          end
          default: m_mode = M_IDLE;
        endcase
      end
      if (bus.sos_mode || pre_mode == M_SOS) m_calls = 3'b000;
      else for (int i = 0; i < 3; i++) begin
        if (i == clr) m_calls[i] = 1'b0;
        else if (fall[i] && !(pre_mode == M_DOOR && i == door_floor)) m_calls[i] = 1'b1;
      end
    end
    m_run = 1'b1; m_arr = arr_n; m_step = step_n;
    b_hist[2] = b_hist[1]; b_hist[1] = b_hist[0]; b_hist[0] = bus.button_n;
    mv_hist[2] = mv_hist[1]; mv_hist[1] = mv_hist[0]; mv_hist[0] = bus.move_clk;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      check("floor", bus.floor, m_floor);
      check("moving", bus.moving, (m_mode == M_UP || m_mode == M_DOWN));
      check("direction", bus.direction, m_dir);
      check("door_open", bus.door_open, (m_mode == M_DOOR));
      check("pending", bus.pending, m_calls);
      check("arrived", bus.arrived, m_arr);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int f);
    bus.button_n[f] = 1'b0;
    cycles(3);
    bus.button_n[f] = 1'b1;
    cycles(1);
  endtask

  task automatic tick();
    bus.move_clk = 1'b1;
    cycles(3);
    bus.move_clk = 1'b0;
    cycles(3);
  endtask

  // Step one floor, then measure how many cycles the door stays open there.
  task automatic tick_door(output int len);
    int i;
    bus.move_clk = 1'b1;
    cycles(3);
    bus.move_clk = 1'b0;
    i = 0;
    while (!bus.door_open && i < 20) begin cycles(1); i++; end
    check("door_reached", int'(i < 20), 1);
    check("arrived_on_open", bus.arrived, 1);
    len = 0;
    while (bus.door_open && len < 10 * DT) begin len++; cycles(1); end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (i < budget && (bus.moving || bus.door_open || bus.pending != 3'b000)) begin
      tick();
      i++;
    end
    check("idle_reached", int'(i < budget), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_floor"}, bus.floor, 0);
    check({tag, "_direction"}, bus.direction, 1);
    check({tag, "_moving"}, bus.moving, 0);
    check({tag, "_door"}, bus.door_open, 0);
    check({tag, "_pending"}, bus.pending, 0);
    check({tag, "_arrived"}, bus.arrived, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int len, cnt;
    bus.button_n = 3'b111;
    bus.move_clk = 1'b0;
    bus.sos_mode = 1'b0;
    bus.weight_limit_exceeded = 1'b0;
    cycles(3);
    check_reset_values("rst");
    reset_n = 1'b1;
    chk_en = 1'b1;
    cycles(3);

    // single call two floors up
    press(2);
    check("r35_pending", bus.pending, 3'b100);
    cycles(1);
    check("r35_moving", bus.moving, 1);
    tick();
    check("r35_floor1", bus.floor, 1);
    check("r35_no_stop", bus.moving, 1);
    tick_door(len);
    check("r35_dwell", len, DT);
    check("r35_floor2", bus.floor, 2);
    check("r35_idle_pending", bus.pending, 0);
    check("r35_idle_moving", bus.moving, 0);

    // intermediate stop on the way up
    press(0);
    wait_idle(20);
    press(2);
    press(1);
    tick_door(len);
    check("r36_stop1_floor", bus.floor, 1);
    check("r36_dir", bus.direction, 1);
    tick_door(len);
    check("r36_floor2", bus.floor, 2);
    check("r36_dir_end", bus.direction, 1);
    wait_idle(20);

    // serve the top, then reverse for the bottom
    press(0);
    wait_idle(20);
    press(2);
    tick();
    press(0);
    check("r37_pending", bus.pending, 3'b101);
    tick_door(len);
    check("r37_reverse_dir", bus.direction, 0);
    check("r37_reverse_moving", bus.moving, 1);
    tick();
    tick_door(len);
    check("r37_floor0", bus.floor, 0);
    wait_idle(20);

    // overload holds the door
    press(0);
    bus.weight_limit_exceeded = 1'b1;
    cycles(3 * DT);
    check("r38_held", bus.door_open, 1);
    bus.weight_limit_exceeded = 1'b0;
    cnt = 0;
    do begin cycles(1); cnt++; end while (bus.door_open && cnt < 10 * DT);
    check("r38_close_after", cnt, DT);

    // emergency stop while travelling
    press(2);
    press(0);
    check("r39_pending", bus.pending, 3'b101);
    bus.sos_mode = 1'b1;
    cycles(1);
    check("r39_moving", bus.moving, 0);
    check("r39_pending_clr", bus.pending, 0);
    tick();
    tick();
    check("r39_floor_held", bus.floor, 0);
    bus.sos_mode = 1'b0;
    cycles(2);
    check("r39_exit_door", bus.door_open, 0);

    // reset in the middle of a dwell at the top
    press(2);
    tick();
    bus.move_clk = 1'b1;
    cycles(3);
    bus.move_clk = 1'b0;
    cycles(3);
    check("r40_door_top", bus.door_open, 1);
    check("r40_floor_top", bus.floor, 2);
    #1 reset_n = 1'b0;
    #1 check_reset_values("r40");
    cycles(2);
    reset_n = 1'b1;
    cycles(2);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: press($urandom_range(0, 2));
        4, 5, 6:    tick();
        7: begin
          bus.weight_limit_exceeded = 1'b1;
          cycles($urandom_range(1, 2 * DT));
          bus.weight_limit_exceeded = 1'b0;
        end
        8: begin
          bus.sos_mode = 1'b1;
          cycles($urandom_range(1, 4));
          bus.sos_mode = 1'b0;
        end
        default: cycles($urandom_range(1, 10));
      endcase
      if (it == 200) begin
        #2 reset_n = 1'b0;
        #1 check_reset_values("rnd_rst");
        cycles(1);
        reset_n = 1'b1;
      end
    end
    cycles(2);
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
